tm1640_frame_sequencer: RTL

- Upstream stage of the TM1640 serial driver on the 9-digit 7-segment PMOD.
- Takes 9 hex digit nibbles, decimal points, brightness and display-on state, and encodes digits to segment patterns.
- On request, issues a complete display frame to the driver as a byte stream over the driver's latch/byte/end/busy interface: data command, address command, NUM_DIGITS segment bytes, then display-control command.
- Replaces the hard-coded instruction list in top-level designs.

---
 rtl/tm1640_frame_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tm1640_frame_sequencer.sv
// Builds a TM1640 display frame from hex digits and streams it, one byte per handshake,
// to the serial driver: data cmd, address cmd, NUM_DIGITS segment bytes, display-control cmd.
module tm1640_frame_sequencer #(
  parameter int NUM_DIGITS  = 9,
  parameter int START_ADDR  = 0,
  parameter int AUTO_INIT   = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [2:0]              brightness,
  input  logic                    disp_on,
  input  logic                    update,
  output logic                    ready,
  output logic                    frame_done,
  output logic                    err,
  output logic                    tm_latch,
  output logic [7:0]              tm_byte,
  output logic                    tm_end,
  input  logic                    tm_busy
);

  localparam int NB = NUM_DIGITS + 3;
  localparam int IW = $clog2(NB);
  localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t                         state, state_nxt;
  logic                           pending;
  logic [IW-1:0]                  idx, idx_nxt;
  logic [CW-1:0]                  cnt;
  logic [NUM_DIGITS-1:0][3:0]     dig_q;
  logic [NUM_DIGITS-1:0]          dp_q;
  logic [2:0]                     br_q;
  logic                           on_q;
  logic [NB-1:0][8:0]             frame;   // {end, byte} per frame slot
  logic                           last, timed_out, issue, done_set, to_set;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  4'hF: seg7 = 7'h71;
    endcase
  endfunction

  // Frame is derived only from the snapshot, so inputs changing mid-frame are invisible.
  always_comb begin
    frame    = '0;
    frame[0] = {1'b1, 8'h40};
    frame[1] = {1'b0, 4'hC, 4'(START_ADDR)};
    for (int i = 0; i < NUM_DIGITS; i++)
      frame[i+2] = {(i == NUM_DIGITS - 1), dp_q[i], seg7(dig_q[i])};
    frame[NB-1] = {1'b1, 4'h8, on_q, br_q};
  end

  assign last      = (idx == IW'(NB - 1));
  assign timed_out = (cnt == CW'(ACK_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (update || pending) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (tm_busy) state_nxt = S_WAIT_DONE;
                   else if (timed_out) state_nxt = S_IDLE;
      S_WAIT_DONE: if (!tm_busy) state_nxt = last ? S_IDLE : S_ISSUE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue    = (state_nxt == S_ISSUE);
    idx_nxt  = (state == S_LOAD) ? '0 : idx + IW'(1);
    done_set = (state == S_WAIT_DONE) && !tm_busy && last;
    to_set   = (state == S_WAIT_ACK) && !tm_busy && timed_out;
    ready    = (state == S_IDLE) && !pending && !update;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= (AUTO_INIT != 0);
      idx        <= '0;
      cnt        <= '0;
      dig_q      <= '0;
      dp_q       <= '0;
      br_q       <= '0;
      on_q       <= 1'b0;
      tm_latch   <= 1'b0;
      tm_byte    <= '0;
      tm_end     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      tm_latch   <= issue;
      frame_done <= done_set;
      if (to_set) err <= 1'b1;
      // Requests arriving mid-frame coalesce into one follow-up frame.
      if (state == S_IDLE) pending <= 1'b0;
      else if (update)     pending <= 1'b1;
      if (state == S_LOAD) begin
        dig_q <= digits;
        dp_q  <= dp;
        br_q  <= brightness;
        on_q  <= disp_on;
      end
      if (issue) begin
        idx               <= idx_nxt;
        {tm_end, tm_byte} <= frame[idx_nxt];
        cnt               <= '0;
      end else if (state == S_WAIT_ACK && !timed_out) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
